// File: rtl/fpu_issue_ctrl_if.sv
// Request/response channel pair between a client and the fpu issue front-end.
// master drives requests and consumes responses; slave is the issue controller.
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_opa;
  logic [31:0]      req_opb;
  logic [2:0]       req_op;
  logic [1:0]       req_rmode;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [7:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_opa, req_opb, req_op, req_rmode, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );

  modport slave (
    input  req_valid, req_opa, req_opb, req_op, req_rmode, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Valid/ready front-end for a fixed-latency, non-stallable fpu: issue, tag tracking, response FIFO.
// Handshake to rsp_valid is LAT+1 cycles; req_ready is withheld once in-flight ops plus FIFO entries reach DEPTH.
module fpu_issue_ctrl #(
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fpu_issue_ctrl_if.slave bus,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  input  logic [31:0] fpu_out,
  input  logic [7:0]  fpu_flags,
  output logic [7:0]  sticky_flags,
  input  logic        flags_clr,
  output logic        busy
);
  localparam int NS = LAT + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  logic [NS-1:0]    stg_vld;
  logic [TAG_W-1:0] stg_tag [NS];

  logic [31:0]      mem_result [DEPTH];
  logic [7:0]       mem_flags  [DEPTH];
  logic [TAG_W-1:0] mem_tag    [DEPTH];
  ptr_t             wr_ptr, rd_ptr;
  cnt_t             fifo_count;

  sum_t inflight, credits_used;
  logic issue, capture, pop, fifo_nonempty;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NS; i++) begin
      inflight = inflight + sum_t'(stg_vld[i]);
    end
  end

  // Credits come from registered state only, so a pop frees its slot one cycle later.
  assign credits_used  = inflight + sum_t'(fifo_count);
  assign bus.req_ready = credits_used < sum_t'(DEPTH);
  assign issue         = bus.req_valid && bus.req_ready;

  assign fifo_nonempty = fifo_count != '0;
  assign capture       = stg_vld[NS-1];
  assign pop           = fifo_nonempty && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_opa   <= '0;
      fpu_opb   <= '0;
      fpu_op    <= '0;
      fpu_rmode <= '0;
    end else if (issue) begin
      fpu_opa   <= bus.req_opa;
      fpu_opb   <= bus.req_opb;
      fpu_op    <= bus.req_op;
      fpu_rmode <= bus.req_rmode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      for (int i = 0; i < NS; i++) begin
        stg_tag[i] <= '0;
      end
    end else begin
      stg_vld    <= {stg_vld[NS-2:0], issue};
      stg_tag[0] <= bus.req_tag;
      for (int i = 1; i < NS; i++) begin
        stg_tag[i] <= stg_tag[i-1];
      end
    end
  end

  // Capture is unconditional: the fpu cannot be stalled and credits reserve the slot.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_result[wr_ptr] <= fpu_out;
      mem_flags[wr_ptr]  <= fpu_flags;
      mem_tag[wr_ptr]    <= stg_tag[NS-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)     rd_ptr <= rd_ptr + ptr_t'(1);
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + cnt_t'(1);
        2'b01:   fifo_count <= fifo_count - cnt_t'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A clear coinciding with a capture leaves only the captured flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (capture) begin
      sticky_flags <= (flags_clr ? 8'h00 : sticky_flags) | fpu_flags;
    end else if (flags_clr) begin
      sticky_flags <= '0;
    end
  end

  assign bus.rsp_valid  = fifo_nonempty;
  assign bus.rsp_result = fifo_nonempty ? mem_result[rd_ptr] : '0;
  assign bus.rsp_flags  = fifo_nonempty ? mem_flags[rd_ptr]  : '0;
  assign bus.rsp_tag    = fifo_nonempty ? mem_tag[rd_ptr]    : '0;

  assign busy = (inflight != '0) || fifo_nonempty;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && !pop && fifo_count == cnt_t'(DEPTH)));
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized and directed bench for fpu_issue_ctrl with a behavioural fixed-latency fpu stand-in.
// Expected responses, credits, busy and sticky flags come from a transaction-level queue model.
module tb_fpu_issue_ctrl;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fpu_opa, fpu_opb, fpu_out;
  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rmode;
  logic [7:0]  fpu_flags, sticky_flags;
  logic        flags_clr, busy;

  fpu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fpu_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .sticky_flags(sticky_flags), .flags_clr(flags_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] res; logic [7:0] flg; } fres_t;

  // Stand-in fpu: a few exact IEEE cases, otherwise a deterministic scramble.
  function automatic fres_t fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    fres_t r;
    if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) begin
      r.res = 32'h40400000; r.flg = 8'h00;
    end else if (op == 3'd3 && b[30:0] == 31'd0) begin
      r.res = {a[31] ^ b[31], 8'hFF, 23'd0}; r.flg = 8'h81;
    end else if (op == 3'd2 && a == 32'h3DCCCCCD && b == 32'h3DCCCCCD) begin
      r.res = 32'h3C23D70B; r.flg = 8'h08;
    end else begin
      r.res = (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
      r.flg = a[7:0] ^ b[31:24] ^ {5'd0, op};
    end
    return r;
  endfunction

  fres_t fp_pipe [LAT];
  always @(posedge clk) begin
    fp_pipe[0] <= fpu_fn(fpu_opa, fpu_opb, fpu_op);
    for (int i = 1; i < LAT; i++) fp_pipe[i] <= fp_pipe[i-1];
  end
  assign fpu_out   = fp_pipe[LAT-1].res;
  assign fpu_flags = fp_pipe[LAT-1].flg;

  typedef struct {
    logic [31:0]      res;
    logic [7:0]       flg;
    logic [TAG_W-1:0] tag;
    int               cap;
  } ent_t;

  ent_t        q[$];
  int          cyc;
  logic [7:0]  m_sticky;
  logic [31:0] m_opa, m_opb;
  logic [2:0]  m_op;
  logic [1:0]  m_rm;
  int          n_checks = 0, n_err = 0, n_acc = 0, n_pop = 0;
  bit          last_hs;
  bit          obs_ready, obs_valid, obs_busy;
  logic [31:0] obs_res;
  logic [7:0]  obs_flg, obs_sticky;
  logic [TAG_W-1:0] obs_tag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0) && (q[0].cap <= cyc);
    obs_ready = bus.req_ready;  obs_valid = bus.rsp_valid;  obs_busy = busy;
    obs_res   = bus.rsp_result; obs_flg   = bus.rsp_flags;  obs_tag  = bus.rsp_tag;
    obs_sticky = sticky_flags;
    chk("req_ready", bus.req_ready, q.size() < DEPTH);
    chk("rsp_valid", bus.rsp_valid, ev);
    if (ev && bus.rsp_valid) begin
      chk("rsp_result", bus.rsp_result, q[0].res);
      chk("rsp_flags", bus.rsp_flags, q[0].flg);
      chk("rsp_tag", bus.rsp_tag, q[0].tag);
    end
    chk("busy", busy, q.size() != 0);
    chk("sticky", sticky_flags, m_sticky);
    chk("fpu_opa", fpu_opa, m_opa);
    chk("fpu_opb", fpu_opb, m_opb);
    chk("fpu_op", fpu_op, m_op);
    chk("fpu_rmode", fpu_rmode, m_rm);
  endtask

  // One clock: check what the previous edge produced, drive the next edge, advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [1:0] rm, input logic [TAG_W-1:0] tg,
                      input logic rdy, input logic clr);
    ent_t e;
    fres_t f;
    bit hs, pp, cap_hit;
    logic [7:0] cap_flg;
    int nxt;
    @(negedge clk);
    check_outputs();
    bus.req_valid = v; bus.req_opa = a; bus.req_opb = b; bus.req_op = op;
    bus.req_rmode = rm; bus.req_tag = tg; bus.rsp_ready = rdy; flags_clr = clr;
    hs = v && bus.req_ready;
    pp = bus.rsp_valid && rdy;
    nxt = cyc + 1;
    cap_hit = 0; cap_flg = '0;
    foreach (q[i]) if (q[i].cap == nxt) begin cap_hit = 1; cap_flg = q[i].flg; end
    if (cap_hit)  m_sticky = (clr ? 8'h00 : m_sticky) | cap_flg;
    else if (clr) m_sticky = 8'h00;
    if (pp) begin
      n_pop++;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (hs) begin
      f = fpu_fn(a, b, op);
      e.res = f.res; e.flg = f.flg; e.tag = tg; e.cap = nxt + LAT + 1;
      q.push_back(e);
      m_opa = a; m_opb = b; m_op = op; m_rm = rm;
      n_acc++;
    end
    last_hs = hs;
    cyc = nxt;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    step(1'b0, '0, '0, '0, '0, '0, rdy, clr);
  endtask

  // Drains with rsp_ready high until a response shows; returns edges since the last handshake.
  task automatic wait_rsp(input int hs_edge, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      idle(1'b1, 1'b0);
      if (obs_valid) begin lat = (cyc - 1) - hs_edge; break; end
    end
    if (lat < 0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic reset_model();
    q.delete();
    m_sticky = '0; m_opa = '0; m_opb = '0; m_op = '0; m_rm = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, hs_edge, acc, nt, run, maxrun;
    rst_n = 1'b0;
    bus.req_valid = 0; bus.req_opa = '0; bus.req_opb = '0; bus.req_op = '0;
    bus.req_rmode = '0; bus.req_tag = '0; bus.rsp_ready = 0; flags_clr = 0;
    reset_model();
    cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // single add, latency and result
    step(1, 32'h3F800000, 32'h40000000, 3'd0, 2'd1, 4'd3, 1, 0);
    hs_edge = cyc;
    wait_rsp(hs_edge, lat);
    chk("add_latency", lat, 5);
    chk("add_result", obs_res, 32'h40400000);
    chk("add_tag", obs_tag, 3);
    chk("add_flags", obs_flg, 0);

    // 16 back-to-back muls with the consumer always ready
    acc = 0; nt = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 26; i++) begin
      if (i < 16) begin
        step(1, $urandom, $urandom, 3'd2, 2'($urandom), 4'(i), 1, 0);
        acc += int'(last_hs);
      end else idle(1, 0);
      if (obs_valid) begin
        chk("stream_tag", obs_tag, nt);
        nt++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    chk("stream_accepts", acc, 16);
    chk("stream_rsp_count", nt, 16);
    chk("stream_consecutive", maxrun, 16);

    // credit exhaustion with the consumer stalled, then a single pop
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, $urandom, $urandom, 3'($urandom_range(0, 5)), 2'($urandom), 4'(i), 0, 0);
      acc += int'(last_hs);
    end
    chk("credit_accepts", acc, DEPTH);
    chk("credit_blocked", obs_ready, 0);
    step(1, $urandom, $urandom, 3'd0, 2'd0, 4'd12, 1, 0);
    step(1, $urandom, $urandom, 3'd1, 2'd0, 4'd13, 0, 0);
    chk("credit_reopen", obs_ready, 1);
    repeat (25) idle(1, 0);
    chk("drain_no_loss", n_pop, n_acc);
    chk("drain_busy", obs_busy, 0);

    // divide by zero sets the sticky bit, a clean add keeps it
    idle(1, 1);
    step(1, 32'h3F800000, 32'h00000000, 3'd3, 2'd0, 4'd5, 1, 0);
    wait_rsp(cyc, lat);
    chk("div_result", obs_res, 32'h7F800000);
    chk("div_flag7", obs_flg[7], 1);
    chk("div_sticky7", obs_sticky[7], 1);
    step(1, 32'h3F800000, 32'h40000000, 3'd0, 2'd0, 4'd6, 1, 0);
    wait_rsp(cyc, lat);
    chk("clean_add_flags", obs_flg, 0);
    chk("sticky7_kept", obs_sticky[7], 1);

    // clear coinciding with an inexact capture, then clear on an idle cycle
    step(1, 32'h3DCCCCCD, 32'h3DCCCCCD, 3'd2, 2'd0, 4'd7, 1, 0);
    repeat (4) idle(1, 0);
    idle(1, 1);
    idle(1, 0);
    chk("clr_with_capture", obs_sticky, 8'h08);
    idle(1, 1);
    idle(1, 0);
    chk("clr_idle", obs_sticky, 0);

    // reset with 3 ops in flight and 2 queued
    for (int i = 0; i < 5; i++) step(1, $urandom, $urandom, 3'($urandom_range(0, 5)), 2'($urandom), 4'(i), 0, 0);
    idle(0, 0);
    idle(0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_fpu_opa", fpu_opa, 0);
    chk("rst_fpu_opb", fpu_opb, 0);
    chk("rst_fpu_op", fpu_op, 0);
    chk("rst_fpu_rmode", fpu_rmode, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sticky", sticky_flags, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    bus.req_valid = 0; bus.rsp_ready = 0; flags_clr = 0;
    reset_model();
    @(negedge clk) rst_n = 1'b1;
    step(1, 32'h3F800000, 32'h40000000, 3'd0, 2'd0, 4'd9, 1, 0);
    wait_rsp(cyc, lat);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_result", obs_res, 32'h40400000);
    chk("post_rst_tag", obs_tag, 9);

    // randomized traffic
    n_acc = 0; n_pop = 0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom, 3'($urandom_range(0, 5)),
           2'($urandom), 4'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    repeat (30) idle(1, 0);
    chk("random_no_loss", n_pop, n_acc);
    chk("random_idle_busy", obs_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
